axi4_burst_mem_slave: RTL and testbench

//  AXI4 full slave over a byte-enable, simple-dual-port memory. Generation-2 memory slave for test fabrics.

---
 rtl/axi4_pkg.sv | 56 +++++
 rtl/axi4_burst_mem_slave_if.sv | 67 ++++++
 rtl/ram_be.sv | 44 ++++
 rtl/axi4_burst_mem_slave.sv | 228 ++++++++++++++++++++++
 tb/tb_axi4_burst_mem_slave.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_pkg.sv
// Shared types, response codes and the burst address generator used by both
// the write and the read side of the AXI4 burst memory slave.
package axi4_pkg;

    localparam int unsigned NA_W = 64;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_DATA
    } r_state_e;

    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
    } burst_cfg_t;

    // Byte address of the following beat; illegal WRAP lengths and the reserved code fall back to INCR.
    function automatic logic [NA_W-1:0] next_addr(
        input logic [NA_W-1:0] addr,
        input logic [1:0]      burst,
        input logic [7:0]      len,
        input logic [2:0]      size
    );
        logic [NA_W-1:0] step;
        logic [NA_W-1:0] mask;
        logic            wrap_ok;
        step    = NA_W'(1) << size;
        mask    = ((NA_W'(len) + NA_W'(1)) << size) - NA_W'(1);
        wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        if (burst == BURST_FIXED) begin
            next_addr = addr;
        end else if ((burst == BURST_WRAP) && wrap_ok) begin
            next_addr = (addr & ~mask) | ((addr + step) & mask);
        end else begin
            next_addr = addr + step;
        end
    endfunction

endpackage

// File: rtl/axi4_burst_mem_slave_if.sv
// AXI4 five-channel bundle between an interconnect master and the memory slave.
interface axi4_burst_mem_slave_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4
);
    logic                awvalid;
    logic                awready;
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;

    logic                wvalid;
    logic                wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;

    logic                bvalid;
    logic                bready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;

    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;

    logic                rvalid;
    logic                rready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bid, bresp,
        input  bready,
        input  arvalid, arid, araddr, arlen, arsize, arburst,
        output arready,
        output rvalid, rid, rdata, rresp, rlast,
        input  rready
    );

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bid, bresp,
        output bready,
        output arvalid, arid, araddr, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rid, rdata, rresp, rlast,
        output rready
    );

endinterface

// File: rtl/ram_be.sv
// Simple dual-port RAM: per-byte write enables, registered one-cycle read.
// A same-address read and write in one cycle returns the old word.
module ram_be #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned WORDS     = 256,
    parameter int unsigned AW        = 8,
    parameter string       INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [DATA_W/8-1:0] we,
    input  logic [AW-1:0]       waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                re,
    input  logic                rclr,
    input  logic [AW-1:0]       raddr,
    output logic [DATA_W-1:0]   rdata
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [WORDS];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    always_ff @(posedge clk) begin : mem_write
        for (int b = 0; b < STRB_W; b++) begin
            if (we[b]) mem_q[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end

    // rclr turns an erroring beat into zero data without a second register stage.
    always_comb begin : rd_next
        rdata_d = rdata_q;
        if (re) rdata_d = rclr ? '0 : mem_q[raddr];
    end

    always_ff @(posedge clk) begin : rd_reg
        if (!resetn) rdata_q <= '0;
        else         rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axi4_burst_mem_slave.sv
// AXI4 full slave over a byte-enable dual-port RAM: independent read and write
// burst engines with FIXED/INCR/WRAP addressing, WSTRB and SLVERR reporting.
module axi4_burst_mem_slave
    import axi4_pkg::*;
#(
    parameter int unsigned G_ADDR_WIDTH  = 32,
    parameter int unsigned G_DATA_WIDTH  = 32,
    parameter int unsigned G_ID_WIDTH    = 4,
    parameter int unsigned G_MEM_WORDS   = 256,
    parameter string       MEM_INIT_FILE = ""
) (
    input logic                   clk,
    input logic                   resetn,
    axi4_burst_mem_slave_if.slave s
);
    localparam int unsigned STRB_W     = G_DATA_WIDTH / 8;
    localparam int unsigned OFF_W      = $clog2(STRB_W);
    localparam int unsigned MEM_AW     = (G_MEM_WORDS > 1) ? $clog2(G_MEM_WORDS) : 1;
    localparam logic [2:0]  LEGAL_SIZE = 3'(OFF_W);

    // ---------------- write channel state ----------------
    w_state_e                w_state_q, w_state_d;
    logic [G_ADDR_WIDTH-1:0] waddr_q, waddr_d;
    burst_cfg_t              wcfg_q, wcfg_d;
    logic [7:0]              wbeat_q, wbeat_d;
    logic                    werr_q, werr_d;
    logic                    awready_q, awready_d;
    logic                    wready_q, wready_d;
    logic                    bvalid_q, bvalid_d;
    logic [G_ID_WIDTH-1:0]   bid_q, bid_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [G_ADDR_WIDTH-1:0] w_widx;
    logic                    w_beat_err;
    logic                    w_at_len;
    logic [STRB_W-1:0]       ram_we;

    // ---------------- read channel state ----------------
    r_state_e                r_state_q, r_state_d;
    logic [G_ADDR_WIDTH-1:0] raddr_q, raddr_d;
    burst_cfg_t              rcfg_q, rcfg_d;
    logic [7:0]              rbeat_q, rbeat_d;
    logic                    arready_q, arready_d;
    logic                    rvalid_q, rvalid_d;
    logic [G_ID_WIDTH-1:0]   rid_q, rid_d;
    logic [1:0]              rresp_q, rresp_d;
    logic                    rlast_q, rlast_d;
    logic [G_ADDR_WIDTH-1:0] r_widx;
    logic                    r_beat_err;
    logic                    ram_re;

    // Write engine: accept AW, absorb beats until len or wlast, then respond.
    always_comb begin : w_next
        w_state_d  = w_state_q;
        waddr_d    = waddr_q;
        wcfg_d     = wcfg_q;
        wbeat_d    = wbeat_q;
        werr_d     = werr_q;
        bid_d      = bid_q;
        bresp_d    = bresp_q;
        ram_we     = '0;
        w_widx     = waddr_q >> OFF_W;
        w_beat_err = (wcfg_q.size != LEGAL_SIZE) || (w_widx >= G_ADDR_WIDTH'(G_MEM_WORDS));
        w_at_len   = (wbeat_q == wcfg_q.len);

        unique case (w_state_q)
            W_IDLE: begin
                if (s.awvalid && awready_q) begin
                    waddr_d   = s.awaddr;
                    wcfg_d    = '{len: s.awlen, size: s.awsize, burst: s.awburst};
                    bid_d     = s.awid;
                    wbeat_d   = 8'd0;
                    werr_d    = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (s.wvalid && wready_q) begin
                    if (!w_beat_err && resetn) ram_we = s.wstrb;
                    // A missing or premature wlast is a protocol error but still closes the burst.
                    werr_d = werr_q | w_beat_err | (w_at_len != s.wlast);
                    if (w_at_len || s.wlast) begin
                        bresp_d   = werr_d ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end else begin
                        waddr_d = G_ADDR_WIDTH'(next_addr(NA_W'(waddr_q), wcfg_q.burst,
                                                          wcfg_q.len, wcfg_q.size));
                        wbeat_d = wbeat_q + 8'd1;
                    end
                end
            end
            W_RESP: begin
                if (s.bready && bvalid_q) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase

        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    always_ff @(posedge clk) begin : w_regs
        if (!resetn) begin
            w_state_q <= W_IDLE;
            waddr_q   <= '0;
            wcfg_q    <= '0;
            wbeat_q   <= '0;
            werr_q    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            waddr_q   <= waddr_d;
            wcfg_q    <= wcfg_d;
            wbeat_q   <= wbeat_d;
            werr_q    <= werr_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Read engine: one fetch cycle per beat, then hold the beat until rready.
    always_comb begin : r_next
        r_state_d  = r_state_q;
        raddr_d    = raddr_q;
        rcfg_d     = rcfg_q;
        rbeat_d    = rbeat_q;
        rid_d      = rid_q;
        rresp_d    = rresp_q;
        rlast_d    = rlast_q;
        ram_re     = 1'b0;
        r_widx     = raddr_q >> OFF_W;
        r_beat_err = (rcfg_q.size != LEGAL_SIZE) || (r_widx >= G_ADDR_WIDTH'(G_MEM_WORDS));

        unique case (r_state_q)
            R_IDLE: begin
                if (s.arvalid && arready_q) begin
                    raddr_d   = s.araddr;
                    rcfg_d    = '{len: s.arlen, size: s.arsize, burst: s.arburst};
                    rid_d     = s.arid;
                    rbeat_d   = 8'd0;
                    r_state_d = R_FETCH;
                end
            end
            R_FETCH: begin
                ram_re    = 1'b1;
                rresp_d   = r_beat_err ? RESP_SLVERR : RESP_OKAY;
                rlast_d   = (rbeat_q == rcfg_q.len);
                r_state_d = R_DATA;
            end
            R_DATA: begin
                if (s.rready && rvalid_q) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        raddr_d   = G_ADDR_WIDTH'(next_addr(NA_W'(raddr_q), rcfg_q.burst,
                                                            rcfg_q.len, rcfg_q.size));
                        rbeat_d   = rbeat_q + 8'd1;
                        r_state_d = R_FETCH;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
    end

    always_ff @(posedge clk) begin : r_regs
        if (!resetn) begin
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            rcfg_q    <= '0;
            rbeat_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            rcfg_q    <= rcfg_d;
            rbeat_q   <= rbeat_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rid_q     <= rid_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    ram_be #(
        .DATA_W    (G_DATA_WIDTH),
        .WORDS     (G_MEM_WORDS),
        .AW        (MEM_AW),
        .INIT_FILE (MEM_INIT_FILE)
    ) u_ram (
        .clk    (clk),
        .resetn (resetn),
        .we     (ram_we),
        .waddr  (MEM_AW'(w_widx)),
        .wdata  (s.wdata),
        .re     (ram_re),
        .rclr   (r_beat_err),
        .raddr  (MEM_AW'(r_widx)),
        .rdata  (s.rdata)
    );

    assign s.awready = awready_q;
    assign s.wready  = wready_q;
    assign s.bvalid  = bvalid_q;
    assign s.bid     = bid_q;
    assign s.bresp   = bresp_q;
    assign s.arready = arready_q;
    assign s.rvalid  = rvalid_q;
    assign s.rid     = rid_q;
    assign s.rresp   = rresp_q;
    assign s.rlast   = rlast_q;

endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// Randomized bench for axi4_burst_mem_slave, checked against a word-array
// memory model and burst address rules computed with plain arithmetic.
module tb_axi4_burst_mem_slave;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned IDW   = 4;
    localparam int unsigned WORDS = 256;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    axi4_burst_mem_slave_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IDW)) bus ();

    axi4_burst_mem_slave #(
        .G_ADDR_WIDTH  (AW),
        .G_DATA_WIDTH  (DW),
        .G_ID_WIDTH    (IDW),
        .G_MEM_WORDS   (WORDS),
        .MEM_INIT_FILE ("")
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .s      (bus.slave)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model [WORDS];
    logic [31:0] wq_data [$];
    logic [3:0]  wq_strb [$];
    logic [31:0] rd_obs [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Word touched by beat i of a burst starting at word w0.
    function automatic int unsigned exp_word(input int unsigned w0, input int len,
                                             input int burst, input int i);
        int unsigned n;
        n = int'(len) + 1;
        if (burst == 0) return w0;
        if (burst == 2 && (n == 2 || n == 4 || n == 8 || n == 16))
            return (w0 / n) * n + ((w0 % n) + i) % n;
        return w0 + i;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input int n);
        wq_data.delete();
        wq_strb.delete();
        for (int i = 0; i < n; i++) begin
            wq_data.push_back($urandom);
            wq_strb.push_back(4'($urandom_range(0, 15)));
        end
    endtask

    // abort >= 0 stops after that many beats without collecting B.
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input int size, input int burst, input int wlast_pos,
                            input int bstall, input int abort, input string tag);
        int          nbeats;
        int          cyc;
        bit          err;
        logic        rdy;
        int unsigned w0;
        int unsigned w;
        w0     = addr >> 2;
        nbeats = (wlast_pos < len) ? wlast_pos + 1 : len + 1;
        err    = (size != 2) || (wlast_pos != len);
        bus.awvalid = 1'b1;
        bus.awid    = id;
        bus.awaddr  = addr;
        bus.awlen   = 8'(len);
        bus.awsize  = 3'(size);
        bus.awburst = 2'(burst);
        cyc = 0;
        do begin rdy = bus.awready; tick(); cyc++; end while (!rdy && cyc < 200);
        bus.awvalid = 1'b0;
        if (!rdy) begin chk({tag, "_aw_timeout"}, 1, 0); return; end
        for (int i = 0; i < nbeats; i++) begin
            if (abort >= 0 && i == abort) return;
            repeat ($urandom_range(0, 1)) tick();
            bus.wvalid = 1'b1;
            bus.wdata  = wq_data[i];
            bus.wstrb  = wq_strb[i];
            bus.wlast  = (i == wlast_pos);
            cyc = 0;
            do begin rdy = bus.wready; tick(); cyc++; end while (!rdy && cyc < 200);
            bus.wvalid = 1'b0;
            bus.wlast  = 1'b0;
            if (!rdy) begin chk($sformatf("%s_w%0d_timeout", tag, i), 1, 0); return; end
            w = exp_word(w0, len, burst, i);
            if (size != 2 || w >= WORDS) begin
                err = 1'b1;
            end else begin
                for (int b = 0; b < 4; b++)
                    if (wq_strb[i][b]) model[w][b*8 +: 8] = wq_data[i][b*8 +: 8];
            end
        end
        if (abort >= 0) return;
        cyc = 0;
        while (!bus.bvalid && cyc < 200) begin tick(); cyc++; end
        if (!bus.bvalid) begin chk({tag, "_b_timeout"}, 1, 0); return; end
        chk({tag, "_bid"}, 64'(bus.bid), 64'(id));
        chk({tag, "_bresp"}, 64'(bus.bresp), err ? 64'd2 : 64'd0);
        for (int k = 0; k < bstall; k++) begin
            tick();
            chk($sformatf("%s_bhold%0d", tag, k), {bus.bvalid, 4'(bus.bid), 2'(bus.bresp)},
                {1'b1, id, err ? 2'b10 : 2'b00});
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        chk({tag, "_b_drop"}, 64'(bus.bvalid), 0);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input int rstall, input string tag);
        int          cyc;
        logic        rdy;
        int unsigned w0;
        int unsigned w;
        bit          bad;
        logic [31:0] exp_d;
        w0 = addr >> 2;
        bus.arvalid = 1'b1;
        bus.arid    = id;
        bus.araddr  = addr;
        bus.arlen   = 8'(len);
        bus.arsize  = 3'(size);
        bus.arburst = 2'(burst);
        cyc = 0;
        do begin rdy = bus.arready; tick(); cyc++; end while (!rdy && cyc < 200);
        bus.arvalid = 1'b0;
        if (!rdy) begin chk({tag, "_ar_timeout"}, 1, 0); return; end
        for (int i = 0; i <= len; i++) begin
            cyc = 0;
            while (!bus.rvalid && cyc < 200) begin tick(); cyc++; end
            if (!bus.rvalid) begin chk($sformatf("%s_r%0d_timeout", tag, i), 1, 0); return; end
            w     = exp_word(w0, len, burst, i);
            bad   = (size != 2) || (w >= WORDS);
            exp_d = bad ? 32'h0 : model[w];
            chk($sformatf("%s_rid%0d", tag, i), 64'(bus.rid), 64'(id));
            chk($sformatf("%s_rdata%0d", tag, i), 64'(bus.rdata), 64'(exp_d));
            chk($sformatf("%s_rresp%0d", tag, i), 64'(bus.rresp), bad ? 64'd2 : 64'd0);
            chk($sformatf("%s_rlast%0d", tag, i), 64'(bus.rlast), 64'(i == len));
            rd_obs.push_back(bus.rdata);
            for (int k = 0; k < rstall; k++) begin
                tick();
                chk($sformatf("%s_rhold%0d_%0d", tag, i, k), {bus.rvalid, 4'(bus.rid), bus.rdata},
                    {1'b1, id, exp_d});
            end
            bus.rready = 1'b1;
            tick();
            bus.rready = 1'b0;
        end
        chk({tag, "_r_drop"}, 64'(bus.rvalid), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t6_keep0;
        logic [31:0] t6_keep1;
        {bus.awvalid, bus.awid, bus.awaddr, bus.awlen, bus.awsize, bus.awburst} = '0;
        {bus.wvalid, bus.wdata, bus.wstrb, bus.wlast, bus.bready} = '0;
        {bus.arvalid, bus.arid, bus.araddr, bus.arlen, bus.arsize, bus.arburst, bus.rready} = '0;

        // Reset state
        resetn = 1'b0;
        repeat (3) tick();
        chk("rst_ready", {bus.awready, bus.wready, bus.arready}, 0);
        chk("rst_valid", {bus.bvalid, bus.rvalid, bus.rlast}, 0);
        chk("rst_ids", {bus.bid, bus.rid, bus.bresp, bus.rresp}, 0);
        chk("rst_rdata", 64'(bus.rdata), 0);
        resetn = 1'b1;
        tick();

        // Fill the whole memory with a 256-beat burst, then read it all back.
        fill_random(256);
        foreach (wq_strb[i]) wq_strb[i] = 4'hF;
        do_write(4'h0, 32'h0, 255, 2, 1, 255, 0, -1, "init_w");
        do_read(4'h0, 32'h0, 255, 2, 1, 0, "init_r");

        // T1
        wq_data = '{32'd1, 32'd2, 32'd3, 32'd4};
        wq_strb = '{4'hF, 4'hF, 4'hF, 4'hF};
        do_write(4'h1, 32'h10, 3, 2, 1, 3, 2, -1, "t1_w");
        rd_obs.delete();
        do_read(4'h1, 32'h10, 3, 2, 1, 1, "t1_r");
        for (int i = 0; i < 4; i++) chk($sformatf("t1_val%0d", i), 64'(rd_obs[i]), 64'(i + 1));

        // T2
        wq_data = '{32'hAABBCCDD};
        wq_strb = '{4'hF};
        do_write(4'h2, 32'h0, 0, 2, 1, 0, 0, -1, "t2_w0");
        wq_data = '{32'h11223344};
        wq_strb = '{4'b0101};
        do_write(4'h2, 32'h0, 0, 2, 1, 0, 0, -1, "t2_w1");
        rd_obs.delete();
        do_read(4'h2, 32'h0, 0, 2, 1, 0, "t2_r");
        chk("t2_merge", 64'(rd_obs[0]), 64'h0000_0000_AA22_CC44);

        // T3: WRAP then FIXED at 0x38
        wq_data = '{32'hCAFE0000, 32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003};
        wq_strb = '{4'hF, 4'hF, 4'hF, 4'hF};
        do_write(4'h3, 32'h38, 3, 2, 2, 3, 0, -1, "t3_wrap_w");
        do_read(4'h3, 32'h38, 3, 2, 2, 0, "t3_wrap_r");
        rd_obs.delete();
        do_read(4'h3, 32'h30, 3, 2, 1, 0, "t3_lin_r");
        chk("t3_wordC", 64'(rd_obs[0]), 64'h0000_0000_CAFE_0002);
        chk("t3_wordD", 64'(rd_obs[1]), 64'h0000_0000_CAFE_0003);
        chk("t3_wordE", 64'(rd_obs[2]), 64'h0000_0000_CAFE_0000);
        chk("t3_wordF", 64'(rd_obs[3]), 64'h0000_0000_CAFE_0001);
        wq_data = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
        do_write(4'h3, 32'h38, 3, 2, 0, 3, 0, -1, "t3_fix_w");
        rd_obs.delete();
        do_read(4'h3, 32'h38, 0, 2, 1, 0, "t3_fix_r");
        chk("t3_fixed_last", 64'(rd_obs[0]), 64'hB3);

        // T4: burst crossing the end of memory
        do_read(4'h4, (WORDS - 2) * 4, 3, 2, 1, 0, "t4_r");
        fill_random(4);
        do_write(4'h4, (WORDS - 2) * 4, 3, 2, 1, 3, 0, -1, "t4_w");
        do_read(4'h4, (WORDS - 2) * 4, 1, 2, 1, 0, "t4_rb");

        // Illegal size, early wlast, missing wlast
        fill_random(4);
        do_write(4'h7, 32'h40, 3, 1, 1, 3, 0, -1, "sz_w");
        do_read(4'h7, 32'h40, 3, 1, 1, 0, "sz_r");
        fill_random(4);
        do_write(4'h8, 32'h50, 3, 2, 1, 1, 0, -1, "early_w");
        fill_random(4);
        do_write(4'h9, 32'h60, 3, 2, 1, 9, 0, -1, "nolast_w");
        do_read(4'h9, 32'h50, 7, 2, 1, 0, "early_r");

        // T5: concurrent write and read on different IDs with 5-cycle stalls
        fill_random(8);
        fork
            do_write(4'h3, 32'h200, 7, 2, 1, 7, 5, -1, "t5_w");
            do_read(4'h5, 32'h100, 7, 2, 1, 5, "t5_r");
        join
        do_read(4'h6, 32'h200, 7, 2, 1, 0, "t5_rb");

        // T6: reset after beat 2 of an 8-beat write
        fill_random(8);
        foreach (wq_strb[i]) wq_strb[i] = 4'hF;
        t6_keep0 = wq_data[0];
        t6_keep1 = wq_data[1];
        do_write(4'hA, 32'h300, 7, 2, 1, 7, 0, 2, "t6_w");
        resetn = 1'b0;
        tick();
        chk("t6_rst_ready", {bus.awready, bus.wready, bus.arready}, 0);
        chk("t6_rst_valid", {bus.bvalid, bus.rvalid}, 0);
        resetn = 1'b1;
        tick();
        fill_random(4);
        do_write(4'hB, 32'h340, 3, 2, 1, 3, 1, -1, "t6_new_w");
        rd_obs.delete();
        do_read(4'hB, 32'h300, 1, 2, 1, 0, "t6_r");
        chk("t6_keep0", 64'(rd_obs[0]), 64'(t6_keep0));
        chk("t6_keep1", 64'(rd_obs[1]), 64'(t6_keep1));

        // Randomized traffic
        for (int t = 0; t < 30; t++) begin
            int          len;
            int          size;
            int          burst;
            int          wlp;
            int          r;
            logic [3:0]  id;
            logic [31:0] addr;
            case ($urandom_range(0, 4))
                0:       len = 0;
                1:       len = 1;
                2:       len = 3;
                3:       len = 7;
                default: len = $urandom_range(0, 20);
            endcase
            burst = $urandom_range(0, 3);
            size  = ($urandom_range(0, 9) == 0) ? 1 : 2;
            addr  = 32'($urandom_range(0, WORDS + 4)) * 4 + 32'($urandom_range(0, 3));
            r     = $urandom_range(0, 9);
            wlp   = len;
            if (r == 0 && len > 0) wlp = len - 1;
            else if (r == 1)       wlp = len + 1;
            id = 4'($urandom_range(0, 15));
            fill_random(len + 2);
            do_write(id, addr, len, size, burst, wlp, $urandom_range(0, 3), -1, $sformatf("rnd%0d_w", t));
            do_read(~id, addr, len, size, burst, $urandom_range(0, 2), $sformatf("rnd%0d_r", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
